// File: rtl/lvt_serial_pkg.sv
// Shared types and size helpers for the LVT serial host.
package lvt_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PUSH,
    WAIT,
    CAPTURE,
    RESP
  } lvt_host_state_e;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Command frame: per port one enable bit, one data word and one address.
  function automatic int calc_f(input int width, input int depth, input int ports);
    return ports * (1 + width + calc_aw(depth));
  endfunction

  // Response: one data word per port.
  function automatic int calc_r(input int width, input int ports);
    return ports * width;
  endfunction

endpackage

// File: rtl/lvt_serial_shifter.sv
// Parallel-load / serial-out and serial-in / parallel-out shift register.
// Shifts left (MSB out first, new bit enters at LSB) and counts shifts since
// the last load; 'last' flags that the shift in progress is the N-th one.
module lvt_serial_shifter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic         ser_out,
  output logic [N-1:0] par_out,
  output logic         last
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  shreg;
  logic [CW-1:0] bit_cnt;

  // Load resets the bit count; each shift moves one bit out and one in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_data;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= (shreg << 1) | N'(ser_in);
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign ser_out = shreg[N-1];
  assign par_out = shreg;
  assign last    = (bit_cnt == CW'(N - 1));

endmodule

// File: rtl/lvt_serial_host.sv
// Host side of the LVT harness serial port: shifts one multi-port command out
// on ser_d, strobes ser_push, then collects the read-back from ser_q.
// Optional: define LVT_SERIAL_HOST_STATS_EN for the stat_cmds/stat_reads counters.
module lvt_serial_host
  import lvt_serial_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 512,
  parameter int PORTS       = 8,
  parameter int CAPTURE_LAT = 4,
  localparam int AW         = calc_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [PORTS*AW-1:0]    cmd_addr,
  input  logic [PORTS*WIDTH-1:0] cmd_data,
  input  logic [PORTS-1:0]       cmd_en,
  input  logic                   cmd_no_read,
  output logic                   ser_d,
  output logic                   ser_push,
  input  logic                   ser_q,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PORTS*WIDTH-1:0] rsp_data
`ifdef LVT_SERIAL_HOST_STATS_EN
  ,
  output logic [15:0]            stat_cmds,
  output logic [15:0]            stat_reads
`endif
);

  localparam int F        = calc_f(WIDTH, DEPTH, PORTS);
  localparam int R        = calc_r(WIDTH, PORTS);
  localparam int WAIT_MAX = (R > CAPTURE_LAT) ? R : CAPTURE_LAT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  lvt_host_state_e state_q, state_d;
  logic              no_read_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              accept;
  logic              frame_load, frame_shift, frame_msb, frame_last;
  logic              rsp_load, rsp_shift, rsp_last, rsp_msb;
  logic [F-1:0]      frame_par;
  logic              unused_bits;

  assign accept = cmd_valid && (state_q == IDLE);

  lvt_serial_shifter #(.N(F)) u_frame (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (frame_load),
    .load_data ({cmd_en, cmd_data, cmd_addr}),
    .shift_en  (frame_shift),
    .ser_in    (1'b0),
    .ser_out   (frame_msb),
    .par_out   (frame_par),
    .last      (frame_last)
  );

  // Cleared on accept so a no-read command reports all zeros.
  lvt_serial_shifter #(.N(R)) u_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rsp_load),
    .load_data ('0),
    .shift_en  (rsp_shift),
    .ser_in    (ser_q),
    .ser_out   (rsp_msb),
    .par_out   (rsp_data),
    .last      (rsp_last)
  );

  assign unused_bits = ^{frame_par, rsp_msb};

  // State, no-read flag and the return-latency down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      no_read_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) no_read_q <= cmd_no_read;
      if (state_q == PUSH)
        wait_cnt_q <= WAIT_W'((CAPTURE_LAT > 1) ? CAPTURE_LAT - 2 : 0);
      else if (state_q == WAIT && wait_cnt_q != '0)
        wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
    end
  end

  // Next state and Moore outputs; with zero latency the push cycle is also the
  // first capture cycle.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    ser_d       = 1'b0;
    ser_push    = 1'b0;
    rsp_valid   = 1'b0;
    frame_load  = 1'b0;
    frame_shift = 1'b0;
    rsp_load    = 1'b0;
    rsp_shift   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          frame_load = 1'b1;
          rsp_load   = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        ser_d       = frame_msb;
        frame_shift = 1'b1;
        if (frame_last) state_d = PUSH;
      end
      PUSH: begin
        ser_push = 1'b1;
        if (no_read_q) begin
          state_d = RESP;
        end else if (CAPTURE_LAT == 0) begin
          rsp_shift = 1'b1;
          state_d   = rsp_last ? RESP : CAPTURE;
        end else if (CAPTURE_LAT == 1) begin
          state_d = CAPTURE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_shift = 1'b1;
        if (rsp_last) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LVT_SERIAL_HOST_STATS_EN
  // Command and read-completion counters, free-running modulo 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmds  <= '0;
      stat_reads <= '0;
    end else begin
      if (accept) stat_cmds <= stat_cmds + 16'd1;
      if (state_q != RESP && state_d == RESP && !no_read_q)
        stat_reads <= stat_reads + 16'd1;
    end
  end
`endif

endmodule

// File: doc/lvt_serial_host.md
Name: lvt_serial_host

Overview:
- Host-side counterpart of the pipelined LVT memory synthesis harness's serial port.
- Accepts one parallel multi-port command (per-port addr, write data, enable) over a valid/ready handshake.
- Serializes the command onto the 1-bit `ser_d` line, then pulses `ser_push`.
- After a fixed return latency, deserializes PORTS*WIDTH bits from `ser_q` into a parallel response.
- Used in FPGA bring-up and in simulation to drive the harness through its pin-limited interface.

Parameters:
- WIDTH, 32, data bits per port
- DEPTH, 512, words per memory; AW = $clog2(DEPTH)
- PORTS, 8, number of memory ports
- CAPTURE_LAT, 4, cycles from the `ser_push` cycle to the first valid `ser_q` bit (>=0)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  host idle, command accepted on valid&&ready
- cmd_addr  in  PORTS*AW  port j addr at [(j+1)*AW-1 -: AW]
- cmd_data  in  PORTS*WIDTH  port j write data at [(j+1)*WIDTH-1 -: WIDTH]
- cmd_en  in  PORTS  per-port write enable
- cmd_no_read  in  1  skip response capture
- ser_d  out  1  serial command bit
- ser_push  out  1  one-cycle capture strobe
- ser_q  in  1  serial return bit
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed on valid&&ready
- rsp_data  out  PORTS*WIDTH  captured read data, same port packing as cmd_data

Behaviour:
- Reset (async, rst_n=0): state IDLE; ser_d=0, ser_push=0, rsp_valid=0, rsp_data=0, cmd_ready=1 after release; all counters cleared.
- Frame length F = PORTS*(1+WIDTH+AW).
- Frame vector is {cmd_en, cmd_data, cmd_addr}, sent MSB-first, one bit per cycle. The first bit sent lands at the far end of the harness chain.
- States and transitions:
  - IDLE: cmd_ready=1. On accept, load the frame shift register and the no_read flag, then go to SHIFT.
  - SHIFT: ser_d = frame MSB; register shifts left each cycle. After exactly F cycles, go to PUSH.
  - PUSH: ser_push=1 and ser_d=0 for one cycle. If no_read, go to RESP with rsp_data=0. Else if CAPTURE_LAT=0, go to CAPTURE. Else go to WAIT.
  - WAIT: CAPTURE_LAT cycles, counting the PUSH cycle as cycle 0, i.e. CAPTURE_LAT-1 cycles in WAIT. Then go to CAPTURE.
  - CAPTURE: R = PORTS*WIDTH cycles. Each edge does rsp_shift <= {rsp_shift, ser_q}, so the first bit received becomes the MSB. After the R-th sample, go to RESP.
  - RESP: rsp_valid=1 and rsp_data holds stable until rsp_ready=1. At that edge go to IDLE and drop rsp_valid.
- ser_d is 0 in every state other than SHIFT. ser_push is 0 in every state other than PUSH.
- Latency, with the accept at edge 0:
  - ser_d carries frame bit F-1 in cycle 1 and bit 0 in cycle F.
  - ser_push is high in cycle F+1.
  - ser_q is sampled in cycles F+1+CAPTURE_LAT through F+CAPTURE_LAT+R.
  - rsp_valid first rises in cycle F+CAPTURE_LAT+R+1.
- No pipelining: one command in flight. cmd_ready=0 from the accept edge until the rsp handshake completes.
- RESP to IDLE costs one cycle, so the next accept occurs no earlier than the cycle after the rsp handshake.
- cmd_* inputs are ignored outside IDLE; changes after accept have no effect.
- Counters are sized $clog2(F+1) and $clog2(max(R,CAPTURE_LAT)+1). No wrap is possible within a frame.
- Reset asserted mid-frame aborts immediately: ser_d and ser_push drop asynchronously and no partial push is issued.

Optional Feature:
- Macro: LVT_SERIAL_HOST_STATS_EN.
- When defined: adds output `stat_cmds` (16 bits) and output `stat_reads` (16 bits).
  - stat_cmds increments on every command accept.
  - stat_reads increments on every RESP entry where no_read=0.
  - Both wrap modulo 2^16 and reset to 0.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package lvt_serial_pkg holds:
  - state enum `lvt_host_state_e` (IDLE, SHIFT, PUSH, WAIT, CAPTURE, RESP);
  - constant functions for AW, F and R, given WIDTH/DEPTH/PORTS.
- Sub-module lvt_serial_shifter: parameterized parallel-load/serial-out plus serial-in/parallel-out register with a bit counter and done flag. Instantiated twice, once for the frame and once for the response.

Test Plan:
All scenarios use WIDTH=4, DEPTH=8 (AW=3), PORTS=2, CAPTURE_LAT=4, giving F=16 and R=8.
- Basic read: accept cmd_en=2'b10, cmd_data=8'hA5, cmd_addr=6'b101011, no_read=0 -> ser_d cycles 1..16 = 1,0,1,0,1,0,0,1,0,1,1,0,1,0,1,1; ser_push high only in cycle 17; ser_q driven 0,0,1,1,1,1,0,0 in cycles 21..28 -> rsp_valid in cycle 29 with rsp_data=8'h3C.
- No-read: same command with no_read=1 -> ser_push in cycle 17, rsp_valid in cycle 18 with rsp_data=0, no ser_q sampling.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_data stable, cmd_ready=0 with cmd_valid=1 presented. Release rsp_ready -> next accept occurs the cycle after the handshake.
- Reset mid-SHIFT: assert rst_n=0 at cycle 8 -> ser_d=0 and ser_push=0 immediately; after release, cmd_ready=1 and no ser_push occurs until a new command completes 16 shift cycles.
- CAPTURE_LAT=0 build: ser_q sampled in cycles 17..24 (the first sample on the push cycle); rsp_valid in cycle 25.
- STATS_EN build: 3 commands, one with no_read=1 -> stat_cmds=3, stat_reads=2.
